adc_scan_sequencer: RTL and testbench

Scheduler that time-shares the single LTC2308 conversion engine among up to eight analog channels. It selects the channel for each conversion, issues start requests to the ADC serial core, and re-tags the pipelined results: the LTC2308 returns channel N's data one frame after N is programmed. Per-channel results and freshness flags are exposed to the Nios CPU over an Avalon-MM slave, so game-input code such as the Tetris joystick and potentiometers reads cached values without touching the ADC.

---
 rtl/adc_seq_pkg.sv | 40 ++++
 rtl/adc_chan_picker.sv | 36 +++
 rtl/adc_scan_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, register map and field layout for the ADC scan sequencer
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_e;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_STATUS  = 4'd1;
  localparam logic [3:0] ADDR_RESULT0 = 4'd2;
  localparam logic [3:0] ADDR_RESULT7 = 4'd9;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_MASK_LSB = 8;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_FRESH_LSB = 8;

  typedef struct packed {
    logic [18:0] rsvd;
    logic        valid;
    logic [11:0] data;
  } result_word_t;

  function automatic logic [31:0] pack_result(input logic valid, input logic [11:0] data);
    result_word_t w;
    w.rsvd  = '0;
    w.valid = valid;
    w.data  = data;
    return w;
  endfunction

endpackage

// File: rtl/adc_chan_picker.sv
// rtl/adc_chan_picker.sv - round-robin search for the next enabled channel after 'last'
module adc_chan_picker
#(
  parameter int NUM_CH = 8
) (
  input  logic [7:0] en_mask_i,
  input  logic [2:0] last_i,
  output logic [2:0] next_o,
  output logic       found_o
);

  logic [7:0] mask_eff;
  logic [2:0] idx;

  always_comb begin
    mask_eff = '0;
    for (int c = 0; c < 8; c++) begin
      if (c < NUM_CH) mask_eff[c] = en_mask_i[c];
    end
  end

  // Walk from the farthest candidate down so the nearest enabled channel after 'last' wins.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = 3'((int'(last_i) + i) % NUM_CH);
      if (mask_eff[idx]) begin
        next_o  = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - time-shares one LTC2308 engine across channels and re-tags pipelined results
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  adc_chan,
  output logic        adc_start,
  input  logic        adc_busy,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  seq_state_e  state_q, state_d;

  logic        run_q, oneshot_q, ie_q;
  logic [7:0]  en_mask_q;
  logic        scan_done_q, err_q;
  logic [7:0]  fresh_q, valid_q;
  logic [11:0] data_q [8];

  logic [2:0]  cur_q, prev_chan_q;
  logic        prev_valid_q, flush_issued_q, scan_oneshot_q;
  logic [31:0] wd_q;
  logic [31:0] readdata_q;

  logic [2:0]  pick_last, pick_next;
  logic        pick_found;
  logic        start_scan, oneshot_drop, take_next, wait_done, flush_done;
  logic        wd_expire, store_en, busy;
  logic        ctrl_wr, stat_wr, res_sel;
  logic [2:0]  res_idx;
  logic [7:0]  store_mask, read_mask;
  logic [31:0] rd_word;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata[31:16], avs_writedata[7:3]};

  // A oneshot starts from the lowest enabled bit, so search as if the last channel was the top one.
  assign pick_last = (state_q == ST_IDLE && !run_q) ? 3'(NUM_CH - 1) : cur_q;

  adc_chan_picker #(.NUM_CH(NUM_CH)) u_picker (
    .en_mask_i (en_mask_q),
    .last_i    (pick_last),
    .next_o    (pick_next),
    .found_o   (pick_found)
  );

  assign wd_expire = (wd_q == 32'(TIMEOUT - 1)) && !adc_done &&
                     ((state_q == ST_WAIT) || (state_q == ST_FLUSH && flush_issued_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_scan   = 1'b0;
    oneshot_drop = 1'b0;
    take_next    = 1'b0;
    wait_done    = 1'b0;
    flush_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_q || oneshot_q) begin
          if (pick_found) begin
            start_scan = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            oneshot_drop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!adc_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_done) begin
          wait_done = 1'b1;
          if (run_q ? pick_found : (scan_oneshot_q && pick_found && (pick_next > cur_q))) begin
            take_next = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_issued_q) begin
          if (adc_done) begin
            flush_done = 1'b1;
            state_d    = ST_IDLE;
          end else if (wd_expire) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_start = 1'b0;
    case (state_q)
      ST_ISSUE: adc_start = !adc_busy;
      ST_FLUSH: adc_start = !flush_issued_q && !adc_busy;
      default:  adc_start = 1'b0;
    endcase
    busy = (state_q != ST_IDLE);
  end

  assign adc_chan = cur_q;

  // Sequencing datapath: channel tracking, pipeline tag and watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q          <= '0;
      prev_chan_q    <= '0;
      prev_valid_q   <= 1'b0;
      flush_issued_q <= 1'b0;
      scan_oneshot_q <= 1'b0;
      wd_q           <= '0;
    end else begin
      if (start_scan || take_next) cur_q <= pick_next;
      if (start_scan) scan_oneshot_q <= !run_q;
      if (wait_done) begin
        prev_chan_q  <= cur_q;
        prev_valid_q <= 1'b1;
      end
      if (flush_done || wd_expire) prev_valid_q <= 1'b0;
      flush_issued_q <= (state_d == ST_FLUSH) && (flush_issued_q || adc_start);
      wd_q <= (state_q == ST_ISSUE || adc_start) ? '0 : wd_q + 32'd1;
    end
  end

  assign ctrl_wr    = avs_write && (avs_address == ADDR_CTRL);
  assign stat_wr    = avs_write && (avs_address == ADDR_STATUS);
  assign res_sel    = (avs_address >= ADDR_RESULT0) && (avs_address <= ADDR_RESULT7);
  assign res_idx    = 3'(avs_address - ADDR_RESULT0);
  assign store_en   = (wait_done || flush_done) && prev_valid_q;
  assign store_mask = store_en ? (8'd1 << prev_chan_q) : 8'd0;
  assign read_mask  = (avs_read && res_sel) ? (8'd1 << res_idx) : 8'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      oneshot_q   <= 1'b0;
      ie_q        <= 1'b0;
      en_mask_q   <= '0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
      fresh_q     <= '0;
      valid_q     <= '0;
      for (int n = 0; n < 8; n++) data_q[n] <= '0;
    end else begin
      if (ctrl_wr) begin
        run_q     <= avs_writedata[CTRL_RUN];
        ie_q      <= avs_writedata[CTRL_IE];
        en_mask_q <= avs_writedata[CTRL_MASK_LSB +: 8];
      end
      oneshot_q <= (oneshot_q && !(start_scan || oneshot_drop)) ||
                   (ctrl_wr && avs_writedata[CTRL_ONESHOT]);

      if (stat_wr && avs_writedata[STAT_DONE]) scan_done_q <= 1'b0;
      if (flush_done && scan_oneshot_q)        scan_done_q <= 1'b1;
      if (stat_wr && avs_writedata[STAT_ERR])  err_q <= 1'b0;
      if (wd_expire)                           err_q <= 1'b1;

      // A store landing with a RESULT read of the same channel keeps it fresh.
      fresh_q <= (fresh_q & ~read_mask) | store_mask;
      valid_q <= valid_q | store_mask;
      if (store_en) data_q[prev_chan_q] <= adc_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (avs_address == ADDR_CTRL) begin
      rd_word[CTRL_RUN]              = run_q;
      rd_word[CTRL_ONESHOT]          = oneshot_q;
      rd_word[CTRL_IE]               = ie_q;
      rd_word[CTRL_MASK_LSB +: 8]    = en_mask_q;
    end else if (avs_address == ADDR_STATUS) begin
      rd_word[STAT_BUSY]             = busy;
      rd_word[STAT_DONE]             = scan_done_q;
      rd_word[STAT_ERR]              = err_q;
      rd_word[STAT_FRESH_LSB +: 8]   = fresh_q;
    end else if (res_sel) begin
      rd_word = pack_result(valid_q[res_idx], data_q[res_idx]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      readdata_q <= '0;
    else if (avs_read) readdata_q <= rd_word;
  end

  assign avs_readdata = readdata_q;
  assign irq          = scan_done_q && ie_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed vector bench with a pipelined LTC2308 frame model
module tb_adc_scan_sequencer;

  localparam int FRAME_LEN = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  adc_chan;
  logic        adc_start;
  logic        adc_busy = 1'b0;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic [3:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [2:0]  log_q[$];
  logic        done_en = 1'b1;
  logic [11:0] data_base = 12'h100;
  logic [2:0]  m_prev = '0;
  logic [2:0]  m_ch;
  logic        m_st;
  logic [11:0] m_data = '0;
  int          m_cnt = 0;

  adc_scan_sequencer #(.NUM_CH(8), .TIMEOUT(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adc_chan      (adc_chan),
    .adc_start     (adc_start),
    .adc_busy      (adc_busy),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // ADC core: each frame returns the channel programmed one frame earlier.
  always begin
    @(negedge clk);
    m_st = adc_start;
    m_ch = adc_chan;
    @(posedge clk);
    #1;
    adc_done = 1'b0;
    if (m_st) begin
      adc_busy = 1'b1;
      m_cnt    = FRAME_LEN;
      log_q.push_back(m_ch);
      m_data   = data_base + 12'(m_prev);
      m_prev   = m_ch;
    end else if (adc_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        adc_busy = 1'b0;
        if (done_en) begin
          adc_done = 1'b1;
          adc_data = m_data;
        end
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [3:0] addr, input logic [31:0] data, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] rd);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    rd          = avs_readdata;
    avs_read    = 1'b0;
  endtask

  task automatic wait_idle(input string name, output logic [31:0] st);
    int n;
    n  = 0;
    st = 32'h1;
    while (st[0] && n < 400) begin
      bus_read(4'd1, st);
      n++;
    end
    check(name, 32'(st[0]), 32'd0);
  endtask

  task automatic wait_log(input string name, input int k);
    int n;
    n = 0;
    while (log_q.size() < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(log_q.size() >= k), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] rd, st;
    int n, n0, nf, bad;

    repeat (3) @(negedge clk);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_adc_chan", 32'(adc_chan), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    add_vec(1'b0, 4'd0, 32'h0, "ctrl_rst");
    add_vec(1'b0, 4'd1, 32'h0, "status_rst");
    for (int a = 2; a <= 9; a++) add_vec(1'b0, 4'(a), 32'h0, "result_rst");
    add_vec(1'b0, 4'd10, 32'h0, "unmapped10");
    add_vec(1'b0, 4'd15, 32'h0, "unmapped15");
    add_vec(1'b1, 4'd12, 32'hFFFF_FFFF, "wr_unmapped");
    add_vec(1'b0, 4'd0, 32'h0, "ctrl_after_unmapped_wr");
    add_vec(1'b0, 4'd1, 32'h0, "status_after_unmapped_wr");
    add_vec(1'b1, 4'd0, 32'h0000_0002, "wr_oneshot_nomask");
    add_vec(1'b0, 4'd0, 32'h0, "oneshot_dropped");
    add_vec(1'b0, 4'd1, 32'h0, "not_busy_nomask");
    add_vec(1'b1, 4'd0, 32'h0000_0004, "wr_ie");
    add_vec(1'b0, 4'd0, 32'h0000_0004, "ctrl_ie");
    add_vec(1'b1, 4'd0, 32'h0, "wr_ctrl_clear");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
        repeat (2) @(negedge clk);
      end else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].data);
      end
    end
    check("no_start_nomask", 32'(log_q.size()), 32'd0);

    // Oneshot over channels 0 and 2 with interrupts enabled.
    log_q.delete();
    bus_write(4'd0, 32'h0000_0506);
    check("start_lat_t1", 32'(adc_start), 32'd0);
    @(negedge clk);
    check("start_lat_t2", 32'(adc_start), 32'd1);
    check("start_chan", 32'(adc_chan), 32'd0);
    wait_idle("os_idle", st);
    check("os_status", st, 32'h0000_0502);
    check("os_irq", 32'(irq), 32'd1);
    check("os_frames", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) check("os_chans", {23'd0, log_q[0], log_q[1], log_q[2]}, {23'd0, 3'd0, 3'd2, 3'd2});
    bus_read(4'd2, rd);
    check("os_result0", rd, 32'h0000_1100);
    bus_read(4'd4, rd);
    check("os_result2", rd, 32'h0000_1102);
    bus_read(4'd1, rd);
    check("os_fresh_cleared", rd, 32'h0000_0002);
    bus_write(4'd1, 32'h0000_0002);
    check("os_irq_cleared", 32'(irq), 32'd0);

    // Continuous over all channels; resumes after the last picked channel (2).
    log_q.delete();
    bus_write(4'd0, 32'h0000_FF01);
    wait_log("cont_frames", 20);
    n0 = log_q.size();
    bus_write(4'd0, 32'h0000_FF00);
    wait_idle("cont_idle", st);
    nf = log_q.size();
    bad = 0;
    for (int i = 0; i < nf - 1; i++) if (int'(log_q[i]) != (3 + i) % 8) bad++;
    check("cont_seq_errors", 32'(bad), 32'd0);
    check("cont_flush_chan", 32'(log_q[nf - 1]), 32'((3 + nf - 2) % 8));
    check("cont_one_flush", 32'((nf - n0) >= 1 && (nf - n0) <= 2), 32'd1);
    for (int c = 0; c < 8; c++) begin
      bus_read(4'(c + 2), rd);
      check("cont_result", rd, 32'h0000_1100 + 32'(c));
    end
    bus_read(4'd1, rd);
    check("cont_status", rd, 32'h0);

    // RESULT[3] read in the very cycle the flush frame delivers ch3.
    log_q.delete();
    data_base = 12'h200;
    bus_write(4'd0, 32'h0000_0802);
    n = 0;
    while (!(log_q.size() == 2 && adc_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("coll_aligned", 32'(adc_done), 32'd1);
    bus_read(4'd5, rd);
    check("coll_old_value", rd, 32'h0000_1103);
    bus_read(4'd1, rd);
    check("coll_fresh_kept", rd, 32'h0000_0802);
    bus_read(4'd5, rd);
    check("coll_new_value", rd, 32'h0000_1203);
    bus_write(4'd1, 32'h0000_0002);

    // Watchdog: no adc_done ever arrives.
    log_q.delete();
    done_en = 1'b0;
    bus_write(4'd0, 32'h0000_0102);
    wait_log("to_started", 1);
    repeat (63) @(negedge clk);
    bus_read(4'd1, rd);
    check("to_before_expire", rd, 32'h0000_0001);
    bus_read(4'd1, rd);
    check("to_expired", rd, 32'h0000_0004);
    bus_read(4'd2, rd);
    check("to_no_store", rd, 32'h0000_1100);
    n = 0;
    while (adc_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    done_en = 1'b1;
    bus_write(4'd1, 32'h0000_0004);
    bus_read(4'd1, rd);
    check("to_err_w1c", rd, 32'h0);

    // Reset in the middle of WAIT, then a fresh oneshot on channel 1.
    log_q.delete();
    bus_write(4'd0, 32'h0000_1002);
    wait_log("rst_scan_started", 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (adc_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    bus_read(4'd6, rd);
    check("rst_result4_cleared", rd, 32'h0);
    bus_read(4'd1, rd);
    check("rst_status_cleared", rd, 32'h0);
    bus_read(4'd0, rd);
    check("rst_ctrl_cleared", rd, 32'h0);
    log_q.delete();
    data_base = 12'h300;
    bus_write(4'd0, 32'h0000_0202);
    wait_log("rst_flush_started", 2);
    bus_read(4'd3, rd);
    check("rst_first_discarded", rd, 32'h0);
    wait_idle("rst_idle", st);
    check("rst_status_done", st, 32'h0000_0202);
    bus_read(4'd3, rd);
    check("rst_result1_flush", rd, 32'h0000_1301);
    check("rst_frames", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) check("rst_chans", {26'd0, log_q[0], log_q[1]}, {26'd0, 3'd1, 3'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
